// File: rtl/p2p_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p2p_reg_pkg
// Description : Shared types and constants for the p2p plugin register file.
// Revision    : 1.0 - initial clocked register file
// ============================================================================
package p2p_reg_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // Data returned for any read whose address is beyond the implemented range
  localparam reg_data_t OUT_OF_RANGE_DATA = '0;

  // Storage index width; a single-register file still needs a 1-bit index
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p2p_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : p2p_reg_file_if
// Description : System access port, internal read clients and write-notify
//               bundle of the p2p register file.
// Revision    : 1.0 - initial clocked register file
// ============================================================================
interface p2p_reg_file_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLIENTS = 2
) ();

  // System (AXI-lite configuration) port
  logic                              sys_reg_en;
  logic                              sys_reg_we;
  logic [DATA_WIDTH/8-1:0]           sys_reg_be;
  logic [ADDR_WIDTH-1:0]             sys_reg_addr;
  logic [DATA_WIDTH-1:0]             sys_reg_din;
  logic [DATA_WIDTH-1:0]             sys_reg_dout;
  logic                              sys_reg_ack;
  logic                              sys_reg_err;

  // Internal read clients, packed client-major
  logic [NUM_CLIENTS-1:0]            int_rd_en;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] int_rd_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] int_rd_data;
  logic [NUM_CLIENTS-1:0]            int_rd_valid;
  logic [NUM_CLIENTS-1:0]            int_rd_err;

  // Write notification
  logic                              reg_wr_pulse;
  logic [ADDR_WIDTH-1:0]             reg_wr_addr;

  modport master (
    output sys_reg_en, sys_reg_we, sys_reg_be, sys_reg_addr, sys_reg_din,
    input  sys_reg_dout, sys_reg_ack, sys_reg_err,
    output int_rd_en, int_rd_addr,
    input  int_rd_data, int_rd_valid, int_rd_err,
    input  reg_wr_pulse, reg_wr_addr
  );

  modport slave (
    input  sys_reg_en, sys_reg_we, sys_reg_be, sys_reg_addr, sys_reg_din,
    output sys_reg_dout, sys_reg_ack, sys_reg_err,
    input  int_rd_en, int_rd_addr,
    output int_rd_data, int_rd_valid, int_rd_err,
    output reg_wr_pulse, reg_wr_addr
  );

endinterface
`default_nettype wire

// File: rtl/p2p_reg_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : p2p_reg_read_port
// Description : One registered read port: range check, data register,
//               one-cycle valid strobe and out-of-range flag.
// Revision    : 1.0 - initial clocked register file
// ============================================================================
module p2p_reg_read_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] rd_word_i,   // storage word at rd_addr_i low bits
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_err_o
);

  import p2p_reg_pkg::*;

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable
  localparam logic [ADDR_WIDTH:0] c_limit = (ADDR_WIDTH+1)'(NUM_REGS);

  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  rd_err_q;

  assign w_in_range = ({1'b0, rd_addr_i} < c_limit);
  assign rd_data_d  = w_in_range ? rd_word_i : DATA_WIDTH'(OUT_OF_RANGE_DATA);

  // Capture data/err only on a request so both hold between valids
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_data_d;
        rd_err_q  <= ~w_in_range;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;

endmodule
`default_nettype wire

// File: rtl/p2p_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : p2p_reg_file
// Description : Clocked register file with one system read/write port,
//               NUM_CLIENTS independent read clients and a write notify.
// Revision    : 1.0 - initial clocked register file
// ============================================================================
module p2p_reg_file #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 64,
  parameter int                    NUM_CLIENTS = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic          axil_aclk,
  input  logic          axil_aresetn,
  p2p_reg_file_if.slave bus
);

  import p2p_reg_pkg::*;

  localparam int                  c_idx_w  = idx_width(NUM_REGS);
  localparam int                  c_nbytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] c_limit  = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0]             mem_q [NUM_REGS];

  logic                              w_sys_wr;
  logic                              w_sys_wr_ok;
  logic                              w_sys_rd;
  logic [DATA_WIDTH-1:0]             w_sys_word;
  logic [DATA_WIDTH-1:0]             w_sys_rd_data;
  logic                              w_sys_rd_valid;
  logic                              w_sys_rd_err;

  logic                              wr_ack_q;
  logic                              wr_err_q;
  logic                              wr_pulse_q;
  logic [ADDR_WIDTH-1:0]             wr_addr_q;

  logic [NUM_CLIENTS*DATA_WIDTH-1:0] w_int_data;
  logic [NUM_CLIENTS-1:0]            w_int_valid;
  logic [NUM_CLIENTS-1:0]            w_int_err;

  assign w_sys_wr    = bus.sys_reg_en & bus.sys_reg_we;
  assign w_sys_rd    = bus.sys_reg_en & ~bus.sys_reg_we;
  assign w_sys_wr_ok = w_sys_wr & ({1'b0, bus.sys_reg_addr} < c_limit);

  // Byte-enable storage update; every read port samples mem_q before this
  // edge commits, so same-cycle collisions are read-before-write
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= RESET_VALUE;
      end
    end else if (w_sys_wr_ok) begin
      for (int k = 0; k < c_nbytes; k++) begin
        if (bus.sys_reg_be[k]) begin
          mem_q[bus.sys_reg_addr[c_idx_w-1:0]][8*k +: 8] <= bus.sys_reg_din[8*k +: 8];
        end
      end
    end
  end

  // Write completion: ack every write, flag out-of-range, notify committed ones
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      wr_ack_q   <= w_sys_wr;
      wr_err_q   <= w_sys_wr & ~w_sys_wr_ok;
      wr_pulse_q <= w_sys_wr_ok;
      if (w_sys_wr_ok) begin
        wr_addr_q <= bus.sys_reg_addr;
      end
    end
  end

  // System reads share the client read-port logic; dout only moves on reads
  assign w_sys_word = mem_q[bus.sys_reg_addr[c_idx_w-1:0]];

  p2p_reg_read_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_sys_rd (
    .clk_i      (axil_aclk),
    .rst_ni     (axil_aresetn),
    .rd_en_i    (w_sys_rd),
    .rd_addr_i  (bus.sys_reg_addr),
    .rd_word_i  (w_sys_word),
    .rd_data_o  (w_sys_rd_data),
    .rd_valid_o (w_sys_rd_valid),
    .rd_err_o   (w_sys_rd_err)
  );

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_addr = bus.int_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_word = mem_q[w_addr[c_idx_w-1:0]];

    p2p_reg_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
    ) u_rd (
      .clk_i      (axil_aclk),
      .rst_ni     (axil_aresetn),
      .rd_en_i    (bus.int_rd_en[i]),
      .rd_addr_i  (w_addr),
      .rd_word_i  (w_word),
      .rd_data_o  (w_int_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid_o (w_int_valid[i]),
      .rd_err_o   (w_int_err[i])
    );
  end

  assign bus.sys_reg_ack  = w_sys_rd_valid | wr_ack_q;
  assign bus.sys_reg_err  = (w_sys_rd_valid & w_sys_rd_err) | wr_err_q;
  assign bus.sys_reg_dout = w_sys_rd_data;
  assign bus.int_rd_data  = w_int_data;
  assign bus.int_rd_valid = w_int_valid;
  assign bus.int_rd_err   = w_int_err;
  assign bus.reg_wr_pulse = wr_pulse_q;
  assign bus.reg_wr_addr  = wr_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_p2p_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_p2p_reg_file
// Description : Self-checking bench for p2p_reg_file with a reference model
//               and expectation queues for the system port and each client.
// Revision    : 1.0 - initial clocked register file
// ============================================================================
`timescale 1ns/1ps
module tb_p2p_reg_file;

  localparam int              AW = 12;
  localparam int              DW = 32;
  localparam int              NR = 64;
  localparam int              NC = 2;
  localparam int              BW = DW / 8;
  localparam logic [DW-1:0]   RV = 32'h5A5A_0F0F;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic          is_rd;
    logic          pulse;
    logic [AW-1:0] addr;
  } sys_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } cli_exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  int            n_cmp = 0;
  int            n_err = 0;

  logic [DW-1:0] model [NR];
  sys_exp_t      sys_q [$];
  cli_exp_t      cli_q [NC][$];
  logic [DW-1:0] exp_dout;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_cdata [NC];

  p2p_reg_file_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(NC)) bus ();

  p2p_reg_file #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_REGS    (NR),
    .NUM_CLIENTS (NC),
    .RESET_VALUE (RV)
  ) dut (
    .axil_aclk    (clk),
    .axil_aresetn (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.sys_reg_en = 1'b0;
    bus.sys_reg_we = 1'b0;
    bus.int_rd_en  = '0;
  endtask

  // Client reads must be driven before a same-cycle system write so the
  // expectation captures the pre-write value
  task automatic drive_cli(input int i, input logic [AW-1:0] addr);
    cli_exp_t e;
    bus.int_rd_en[i]             = 1'b1;
    bus.int_rd_addr[i*AW +: AW]  = addr;
    e.err  = (int'(addr) >= NR);
    e.data = e.err ? '0 : model[addr[5:0]];
    cli_q[i].push_back(e);
  endtask

  task automatic drive_sys(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] din, input logic [BW-1:0] be);
    sys_exp_t e;
    bus.sys_reg_en   = 1'b1;
    bus.sys_reg_we   = we;
    bus.sys_reg_addr = addr;
    bus.sys_reg_din  = din;
    bus.sys_reg_be   = be;
    e.err   = (int'(addr) >= NR);
    e.is_rd = !we;
    e.pulse = we && !e.err;
    e.addr  = addr;
    e.data  = (!we && !e.err) ? model[addr[5:0]] : '0;
    if (e.pulse) begin
      for (int k = 0; k < BW; k++) begin
        if (be[k]) model[addr[5:0]][8*k +: 8] = din[8*k +: 8];
      end
    end
    sys_q.push_back(e);
  endtask

  task automatic test_reset();
    sys_exp_t e;
    cli_exp_t c;
    idle();
    bus.sys_reg_addr = '0; bus.sys_reg_din = '0; bus.sys_reg_be = '0; bus.int_rd_addr = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.sys_reg_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", bus.sys_reg_ack); end
    n_cmp++; if (bus.sys_reg_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.sys_reg_err); end
    n_cmp++; if (bus.sys_reg_dout !== '0) begin n_err++; $display("FAIL rst_dout: got %h want 0", bus.sys_reg_dout); end
    n_cmp++; if (bus.int_rd_valid !== '0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.int_rd_valid); end
    n_cmp++; if (bus.int_rd_err !== '0) begin n_err++; $display("FAIL rst_int_err: got %b want 0", bus.int_rd_err); end
    n_cmp++; if (bus.int_rd_data !== '0) begin n_err++; $display("FAIL rst_int_data: got %h want 0", bus.int_rd_data); end
    n_cmp++; if (bus.reg_wr_pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse: got %b want 0", bus.reg_wr_pulse); end
    n_cmp++; if (bus.reg_wr_addr !== '0) begin n_err++; $display("FAIL rst_waddr: got %h want 0", bus.reg_wr_addr); end
    for (int r = 0; r < NR; r++) model[r] = RV;
    exp_dout = '0; exp_waddr = '0;
    for (int i = 0; i < NC; i++) exp_cdata[i] = '0;
    rst_n = 1'b1;
    @(negedge clk);
    drive_sys(1'b0, 12'd5, '0, '0);
    drive_cli(1, 12'd63);
    @(negedge clk);
    idle();
    e = sys_q.pop_front(); exp_dout = e.data;
    c = cli_q[1].pop_front(); exp_cdata[1] = c.data;
    n_cmp++; if (bus.sys_reg_ack !== 1'b1) begin n_err++; $display("FAIL rd5_ack: got %b want 1", bus.sys_reg_ack); end
    n_cmp++; if (bus.sys_reg_err !== e.err) begin n_err++; $display("FAIL rd5_err: got %b want %b", bus.sys_reg_err, e.err); end
    n_cmp++; if (bus.sys_reg_dout !== exp_dout) begin n_err++; $display("FAIL rd5_dout: got %h want %h", bus.sys_reg_dout, exp_dout); end
    n_cmp++; if (bus.int_rd_valid !== 2'b10) begin n_err++; $display("FAIL rd63_valid: got %b want 10", bus.int_rd_valid); end
    n_cmp++; if (bus.int_rd_data[DW +: DW] !== exp_cdata[1]) begin n_err++; $display("FAIL rd63_data: got %h want %h", bus.int_rd_data[DW +: DW], exp_cdata[1]); end
    n_cmp++; if (bus.int_rd_err[1] !== c.err) begin n_err++; $display("FAIL rd63_err: got %b want %b", bus.int_rd_err[1], c.err); end
    @(negedge clk);
    n_cmp++; if (bus.sys_reg_ack !== 1'b0 || bus.int_rd_valid !== '0) begin n_err++; $display("FAIL strobe_width: got ack=%b valid=%b want 0/00", bus.sys_reg_ack, bus.int_rd_valid); end
    n_cmp++; if (bus.sys_reg_dout !== exp_dout) begin n_err++; $display("FAIL dout_hold: got %h want %h", bus.sys_reg_dout, exp_dout); end
  endtask

  task automatic test_byte_enable();
    sys_exp_t e;
    @(negedge clk);
    drive_sys(1'b1, 12'd3, 32'hAABB_CCDD, 4'b0101);
    @(negedge clk);
    idle();
    e = sys_q.pop_front(); exp_waddr = e.addr;
    n_cmp++; if (bus.sys_reg_ack !== 1'b1 || bus.sys_reg_err !== 1'b0) begin n_err++; $display("FAIL be_wr_ack: got ack=%b err=%b want 1/0", bus.sys_reg_ack, bus.sys_reg_err); end
    n_cmp++; if (bus.reg_wr_pulse !== 1'b1) begin n_err++; $display("FAIL be_wr_pulse: got %b want 1", bus.reg_wr_pulse); end
    n_cmp++; if (bus.reg_wr_addr !== exp_waddr) begin n_err++; $display("FAIL be_wr_addr: got %h want %h", bus.reg_wr_addr, exp_waddr); end
    n_cmp++; if (bus.sys_reg_dout !== exp_dout) begin n_err++; $display("FAIL be_wr_dout_hold: got %h want %h", bus.sys_reg_dout, exp_dout); end
    drive_sys(1'b0, 12'd3, '0, '0);
    @(negedge clk);
    idle();
    e = sys_q.pop_front(); exp_dout = e.data;
    n_cmp++; if (bus.sys_reg_dout !== ((RV & 32'hFF00_FF00) | 32'h00BB_00DD)) begin n_err++; $display("FAIL be_rd_dout: got %h want %h", bus.sys_reg_dout, (RV & 32'hFF00_FF00) | 32'h00BB_00DD); end
    n_cmp++; if (bus.reg_wr_pulse !== 1'b0 || bus.reg_wr_addr !== exp_waddr) begin n_err++; $display("FAIL be_rd_notify: got pulse=%b addr=%h want 0/%h", bus.reg_wr_pulse, bus.reg_wr_addr, exp_waddr); end
  endtask

  task automatic test_collision();
    sys_exp_t e;
    cli_exp_t c;
    @(negedge clk);
    drive_cli(0, 12'd7);
    drive_sys(1'b1, 12'd7, 32'h1234_5678, 4'hF);
    @(negedge clk);
    e = sys_q.pop_front(); exp_waddr = e.addr;
    c = cli_q[0].pop_front(); exp_cdata[0] = c.data;
    n_cmp++; if (bus.reg_wr_pulse !== 1'b1 || bus.reg_wr_addr !== exp_waddr) begin n_err++; $display("FAIL col_notify: got pulse=%b addr=%h want 1/%h", bus.reg_wr_pulse, bus.reg_wr_addr, exp_waddr); end
    n_cmp++; if (bus.int_rd_valid !== 2'b01) begin n_err++; $display("FAIL col_valid: got %b want 01", bus.int_rd_valid); end
    n_cmp++; if (bus.int_rd_data[0 +: DW] !== exp_cdata[0]) begin n_err++; $display("FAIL col_old_data: got %h want %h", bus.int_rd_data[0 +: DW], exp_cdata[0]); end
    idle();
    drive_cli(0, 12'd7);
    @(negedge clk);
    idle();
    c = cli_q[0].pop_front(); exp_cdata[0] = c.data;
    n_cmp++; if (bus.int_rd_data[0 +: DW] !== 32'h1234_5678) begin n_err++; $display("FAIL col_new_data: got %h want 12345678", bus.int_rd_data[0 +: DW]); end
    n_cmp++; if (bus.sys_reg_ack !== 1'b0) begin n_err++; $display("FAIL col_no_ack: got %b want 0", bus.sys_reg_ack); end
  endtask

  task automatic test_back_to_back();
    sys_exp_t e;
    cli_exp_t c;
    @(negedge clk);
    drive_sys(1'b1, 12'd10, 32'h0000_CAFE, 4'hF);
    @(negedge clk);
    idle();
    e = sys_q.pop_front(); exp_waddr = e.addr;
    n_cmp++; if (bus.reg_wr_pulse !== 1'b1 || bus.reg_wr_addr !== exp_waddr) begin n_err++; $display("FAIL b2b_notify: got pulse=%b addr=%h want 1/%h", bus.reg_wr_pulse, bus.reg_wr_addr, exp_waddr); end
    for (int cyc = 0; cyc <= 4; cyc++) begin
      if (cyc > 0) begin
        for (int i = 0; i < NC; i++) begin
          c = cli_q[i].pop_front(); exp_cdata[i] = c.data;
          n_cmp++; if (bus.int_rd_valid[i] !== 1'b1) begin n_err++; $display("FAIL b2b_valid c%0d cyc%0d: got %b want 1", i, cyc, bus.int_rd_valid[i]); end
          n_cmp++; if (bus.int_rd_data[i*DW +: DW] !== exp_cdata[i] || bus.int_rd_err[i] !== c.err) begin n_err++; $display("FAIL b2b_data c%0d cyc%0d: got %h/%b want %h/%b", i, cyc, bus.int_rd_data[i*DW +: DW], bus.int_rd_err[i], exp_cdata[i], c.err); end
        end
      end
      if (cyc < 4) begin
        drive_cli(0, 12'd10);
        drive_cli(1, 12'd10);
      end else begin
        idle();
      end
      @(negedge clk);
    end
    n_cmp++; if (bus.int_rd_valid !== '0) begin n_err++; $display("FAIL b2b_end_valid: got %b want 00", bus.int_rd_valid); end
    n_cmp++; if (bus.int_rd_data !== {2{32'h0000_CAFE}}) begin n_err++; $display("FAIL b2b_hold: got %h want %h", bus.int_rd_data, {2{32'h0000_CAFE}}); end
  endtask

  task automatic test_out_of_range();
    sys_exp_t e;
    cli_exp_t c;
    @(negedge clk);
    drive_cli(1, 12'hFFF);
    drive_sys(1'b1, 12'd64, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    idle();
    e = sys_q.pop_front();
    c = cli_q[1].pop_front(); exp_cdata[1] = c.data;
    n_cmp++; if (bus.sys_reg_ack !== 1'b1 || bus.sys_reg_err !== 1'b1) begin n_err++; $display("FAIL oor_wr: got ack=%b err=%b want 1/1", bus.sys_reg_ack, bus.sys_reg_err); end
    n_cmp++; if (bus.reg_wr_pulse !== 1'b0 || bus.reg_wr_addr !== exp_waddr) begin n_err++; $display("FAIL oor_wr_notify: got pulse=%b addr=%h want 0/%h", bus.reg_wr_pulse, bus.reg_wr_addr, exp_waddr); end
    n_cmp++; if (bus.int_rd_valid[1] !== 1'b1 || bus.int_rd_err[1] !== 1'b1 || bus.int_rd_data[DW +: DW] !== '0) begin n_err++; $display("FAIL oor_cli: got v=%b e=%b d=%h want 1/1/0", bus.int_rd_valid[1], bus.int_rd_err[1], bus.int_rd_data[DW +: DW]); end
    // Address 0 shares low index bits with 64: it must be untouched
    drive_sys(1'b0, 12'd0, '0, '0);
    drive_cli(0, 12'd64);
    @(negedge clk);
    idle();
    e = sys_q.pop_front(); exp_dout = e.data;
    c = cli_q[0].pop_front(); exp_cdata[0] = c.data;
    n_cmp++; if (bus.sys_reg_dout !== exp_dout || bus.sys_reg_err !== 1'b0) begin n_err++; $display("FAIL oor_alias: got %h err=%b want %h/0", bus.sys_reg_dout, bus.sys_reg_err, exp_dout); end
    n_cmp++; if (bus.int_rd_err[0] !== 1'b1 || bus.int_rd_data[0 +: DW] !== '0) begin n_err++; $display("FAIL oor_cli_edge: got e=%b d=%h want 1/0", bus.int_rd_err[0], bus.int_rd_data[0 +: DW]); end
    drive_sys(1'b0, 12'd100, '0, '0);
    @(negedge clk);
    idle();
    e = sys_q.pop_front(); exp_dout = e.data;
    n_cmp++; if (bus.sys_reg_ack !== 1'b1 || bus.sys_reg_err !== 1'b1 || bus.sys_reg_dout !== '0) begin n_err++; $display("FAIL oor_rd: got ack=%b err=%b d=%h want 1/1/0", bus.sys_reg_ack, bus.sys_reg_err, bus.sys_reg_dout); end
  endtask

  task automatic test_write_without_enable();
    sys_exp_t e;
    @(negedge clk);
    bus.sys_reg_en = 1'b0; bus.sys_reg_we = 1'b1; bus.sys_reg_addr = 12'd2;
    bus.sys_reg_din = 32'hFFFF_FFFF; bus.sys_reg_be = 4'hF;
    @(negedge clk);
    idle();
    n_cmp++; if (bus.sys_reg_ack !== 1'b0 || bus.reg_wr_pulse !== 1'b0) begin n_err++; $display("FAIL noen_strobe: got ack=%b pulse=%b want 0/0", bus.sys_reg_ack, bus.reg_wr_pulse); end
    drive_sys(1'b0, 12'd2, '0, '0);
    @(negedge clk);
    idle();
    e = sys_q.pop_front(); exp_dout = e.data;
    n_cmp++; if (bus.sys_reg_dout !== RV) begin n_err++; $display("FAIL noen_data: got %h want %h", bus.sys_reg_dout, RV); end
  endtask

  task automatic test_reset_in_flight();
    sys_exp_t e;
    cli_exp_t c;
    @(negedge clk);
    drive_sys(1'b0, 12'd3, '0, '0);
    drive_cli(0, 12'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    n_cmp++; if (bus.sys_reg_ack !== 1'b0 || bus.int_rd_valid !== '0) begin n_err++; $display("FAIL rif_async: got ack=%b valid=%b want 0/00", bus.sys_reg_ack, bus.int_rd_valid); end
    sys_q.delete();
    for (int i = 0; i < NC; i++) cli_q[i].delete();
    for (int r = 0; r < NR; r++) model[r] = RV;
    exp_dout = '0; exp_waddr = '0;
    for (int i = 0; i < NC; i++) exp_cdata[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (bus.sys_reg_ack !== 1'b0 || bus.int_rd_valid !== '0 || bus.reg_wr_pulse !== 1'b0) begin n_err++; $display("FAIL rif_no_ack: got ack=%b valid=%b pulse=%b want 0", bus.sys_reg_ack, bus.int_rd_valid, bus.reg_wr_pulse); end
      n_cmp++; if (bus.sys_reg_dout !== '0 || bus.reg_wr_addr !== '0) begin n_err++; $display("FAIL rif_outputs: got dout=%h waddr=%h want 0/0", bus.sys_reg_dout, bus.reg_wr_addr); end
    end
    for (int a = 0; a <= NR; a++) begin
      if (a > 0) begin
        e = sys_q.pop_front(); exp_dout = e.data;
        n_cmp++; if (bus.sys_reg_ack !== 1'b1 || bus.sys_reg_dout !== exp_dout) begin n_err++; $display("FAIL rif_sys a%0d: got ack=%b d=%h want 1/%h", a - 1, bus.sys_reg_ack, bus.sys_reg_dout, exp_dout); end
        for (int i = 0; i < NC; i++) begin
          c = cli_q[i].pop_front(); exp_cdata[i] = c.data;
          n_cmp++; if (bus.int_rd_valid[i] !== 1'b1 || bus.int_rd_data[i*DW +: DW] !== exp_cdata[i]) begin n_err++; $display("FAIL rif_cli c%0d step%0d: got v=%b d=%h want 1/%h", i, a - 1, bus.int_rd_valid[i], bus.int_rd_data[i*DW +: DW], exp_cdata[i]); end
        end
      end
      if (a < NR) begin
        drive_sys(1'b0, AW'(a), '0, '0);
        drive_cli(0, AW'(a));
        drive_cli(1, AW'(NR - 1 - a));
      end else begin
        idle();
      end
      @(negedge clk);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_write_without_enable();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/p2p_reg_file.md
Name: p2p_reg_file

Overview:
Clocked, parametrised register file for the p2p plugin. It sits between the AXI-lite system configuration path (one read/write port) and NUM_CLIENTS independent internal read clients, for example one per CMAC datapath. Over the earlier latch-based store it adds:
- synchronous storage with asynchronous reset;
- byte-enable writes;
- registered read responses with valid/ack strobes;
- out-of-range error reporting;
- per-client simultaneous reads;
- a write-notify output.

Parameters:
ADDR_WIDTH, 12, width of the word address on every port.
DATA_WIDTH, 32, register width; must be a multiple of 8.
NUM_REGS, 64, number of implemented registers (addresses 0..NUM_REGS-1); must be at most 2**ADDR_WIDTH.
NUM_CLIENTS, 2, number of internal read ports; must be at least 1.
RESET_VALUE, 0, value loaded into every register on reset (DATA_WIDTH wide).

Ports:
axil_aclk  in  1  clock
axil_aresetn  in  1  asynchronous active-low reset
sys_reg_en  in  1  system access request, single cycle
sys_reg_we  in  1  write qualifier; only meaningful when sys_reg_en=1
sys_reg_be  in  DATA_WIDTH/8  byte enables for writes
sys_reg_addr  in  ADDR_WIDTH  system word address
sys_reg_din  in  DATA_WIDTH  write data
sys_reg_dout  out  DATA_WIDTH  read data, valid when sys_reg_ack=1 and the access was a read
sys_reg_ack  out  1  one-cycle pulse completing every system access
sys_reg_err  out  1  qualified by sys_reg_ack; 1 when the address was out of range
int_rd_en  in  NUM_CLIENTS  per-client read request
int_rd_addr  in  NUM_CLIENTS*ADDR_WIDTH  per-client address; client i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
int_rd_data  out  NUM_CLIENTS*DATA_WIDTH  per-client read data, packed the same way
int_rd_valid  out  NUM_CLIENTS  per-client one-cycle valid
int_rd_err  out  NUM_CLIENTS  per-client out-of-range flag, qualified by int_rd_valid
reg_wr_pulse  out  1  one-cycle pulse when an in-range write commits
reg_wr_addr  out  ADDR_WIDTH  address of that write, held until the next pulse

Behaviour:
Reset:
- Asynchronous assert, synchronous deassert assumed upstream.
- All registers become RESET_VALUE.
- All outputs become 0.
- An access in flight when reset asserts is dropped: no ack or valid after reset deasserts.

System port:
- Accepted in any cycle with sys_reg_en=1; there is no backpressure.
- sys_reg_ack pulses exactly one cycle later for both reads and writes.
- Write (en=1, we=1), in range: byte k of register[addr] takes din byte k when be[k]=1. The new value is visible from the next cycle.
- reg_wr_pulse asserts in the same cycle as sys_reg_ack and reg_wr_addr updates, even when be=0.
- Read (en=1, we=0): sys_reg_dout gets register[addr] as it stood at the request edge.
- sys_reg_dout holds its value until the next system read ack, and is unchanged on write acks.
- Out of range (addr >= NUM_REGS):
  - the write is discarded and there is no reg_wr_pulse;
  - a read returns 0;
  - sys_reg_err=1 with the ack.
- we=1 with en=0 does nothing.

Internal ports:
- Each client is independent. int_rd_en[i] at cycle t gives int_rd_valid[i]=1 at t+1, with int_rd_data[i] = register[addr_i] as it stood at t.
- Back-to-back requests give back-to-back valids (throughput of 1 per cycle per client).
- int_rd_data[i] holds between valids.
- Out-of-range reads return 0 with int_rd_err[i]=1.

Collisions:
- A system write and any read of the same address in the same cycle are read-before-write: the read returns the old value.
- All clients may read the same address simultaneously.

Width rules:
- Addresses are compared unsigned against NUM_REGS.
- Only the low $clog2(NUM_REGS) bits index storage, after the range check.

Decomposition:
- Package p2p_reg_pkg holds:
  - the reg_data_t and reg_addr_t typedefs (parametrised via localparams ADDR_WIDTH/DATA_WIDTH defaults);
  - OUT_OF_RANGE_DATA = '0.
- Sub-module p2p_reg_read_port, instantiated NUM_CLIENTS times via generate. It performs the range check, output register, valid and err for one client. The system read path reuses the same sub-module.

Test Plan:
1. Reset, then system read of addr 5 → ack at +1, dout=0, err=0; int_rd_en[1] on addr 63 → valid[1] at +1, data=0.
2. Write addr 3 din=0xAABBCCDD be=4'b0101, then read addr 3 → dout=0x00BB00DD; reg_wr_pulse=1 with reg_wr_addr=3 on the write ack.
3. Same cycle: system write addr 7 = 0x12345678 (prior 0) and client 0 reads addr 7 → client 0 data=0; client 0 read next cycle → 0x12345678.
4. Both clients read addr 10 (=0xCAFE) every cycle for 4 cycles → valid high for 4 consecutive cycles on both clients, data=0xCAFE on both.
5. System write addr 64 (NUM_REGS=64) → ack with err=1, no reg_wr_pulse; client read addr 0xFFF → valid, err=1, data=0.
6. Reset asserted the cycle after a system read request → no ack after release; all registers read back as RESET_VALUE.
